conv_encoder_213: RTL

- Rate-1/2, constraint-length-3 (2,1,3) convolutional encoder. It is the transmit-side counterpart of the team's Viterbi decoder.
- Accepts a parallel frame of information bits and serialises them MSB first.
- Emits one 2-bit code symbol per handshake on tx, using the same seq_rdy/data_ack symbol interface the decoder consumes.
- Appends 2 zero tail bits per frame so the trellis terminates in state 00.

---
 rtl/conv_encoder_213.sv | 135 +++++++++++++
 1 files changed

// File: rtl/conv_encoder_213.sv
// ---------------------------------------------------------------------------
// conv_encoder_213
//
// Rate-1/2, constraint-length-3 (2,1,3) convolutional encoder. A parallel
// frame of FRAME_LEN information bits is loaded, serialised MSB first, and
// each bit produces one 2-bit code symbol. Two zero tail bits are appended
// so the trellis always ends in state 00 for the matching Viterbi decoder.
//
// Ports
//   clk          system clock, rising edge
//   rst          synchronous active-high reset
//   frame_in     information bits, bit FRAME_LEN-1 transmitted first
//   frame_valid  frame_in valid; loaded when frame_valid && frame_ready
//   frame_ready  encoder idle, can accept a frame
//   tx           current code symbol {G0 output, G1 output}
//   seq_rdy      tx holds a valid symbol
//   data_ack     sink accepts tx; transfer when seq_rdy && data_ack
//   enc_state    encoder shift register {s1, s0}, s1 most recent bit
//   frame_done   one-cycle pulse after the last tail symbol transfers
// ---------------------------------------------------------------------------
module conv_encoder_213 #(
  parameter int         FRAME_LEN = 8,
  parameter logic [2:0] G0        = 3'b111,
  parameter logic [2:0] G1        = 3'b101
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [FRAME_LEN-1:0] frame_in,
  input  logic                 frame_valid,
  output logic                 frame_ready,
  output logic [1:0]           tx,
  output logic                 seq_rdy,
  input  logic                 data_ack,
  output logic [1:0]           enc_state,
  output logic                 frame_done
);

  localparam int CNT_W = (FRAME_LEN < 1) ? 1 : $clog2(FRAME_LEN + 1);
  localparam logic [CNT_W-1:0] LAST_DATA = CNT_W'(FRAME_LEN - 1);
  localparam logic [CNT_W-1:0] LAST_TAIL = CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ENCODE,
    S_TAIL,
    S_DONE
  } state_e;

  state_e               state_q, state_d;
  logic [FRAME_LEN-1:0] frame_q, frame_d;
  logic [CNT_W-1:0]     cnt_q,   cnt_d;
  logic [1:0]           enc_q,   enc_d;

  logic       busy;
  logic       xfer;
  logic       u;
  logic [2:0] w;

  // Next-state logic. Tail bits reuse the data path with u forced to 0.
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path
    // leaves a value unassigned and no latch is inferred.
    busy    = (state_q == S_ENCODE) || (state_q == S_TAIL);
    xfer    = busy && data_ack;
    u       = (state_q == S_ENCODE) && frame_q[FRAME_LEN-1];
    w       = {u, enc_q};
    state_d = state_q;
    frame_d = frame_q;
    cnt_d   = cnt_q;
    enc_d   = enc_q;

    unique case (state_q)
      S_IDLE: begin
        if (frame_valid) begin
          frame_d = frame_in;
          enc_d   = 2'b00;
          cnt_d   = '0;
          state_d = S_ENCODE;
        end
      end
      S_ENCODE: begin
        if (xfer) begin
          enc_d   = {u, enc_q[1]};
          frame_d = frame_q << 1;
          if (cnt_q == LAST_DATA) begin
            cnt_d   = '0;
            state_d = S_TAIL;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_TAIL: begin
        if (xfer) begin
          enc_d = {1'b0, enc_q[1]};
          if (cnt_q == LAST_TAIL) begin
            cnt_d   = '0;
            state_d = S_DONE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Reset wins over any load or transfer in the same cycle, discarding a
  // partial frame without a frame_done pulse.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    if (rst) begin
      state_q <= S_IDLE;
      frame_q <= '0;
      cnt_q   <= '0;
      enc_q   <= 2'b00;
    end else begin
      state_q <= state_d;
      frame_q <= frame_d;
      cnt_q   <= cnt_d;
      enc_q   <= enc_d;
    end
  end

  // Outputs decode registered state only; tx is therefore stable for as
  // long as the sink holds off data_ack.
  assign frame_ready = (state_q == S_IDLE);
  assign seq_rdy     = busy;
  assign frame_done  = (state_q == S_DONE);
  assign enc_state   = enc_q;
  assign tx          = busy ? {^(w & G0), ^(w & G1)} : 2'b00;

endmodule
